// File: rtl/nios_ext_ctrl_pkg.sv
// Shared register map for the Nios ext_ctrl PIO pair (input and output ports).
// Software headers for both ports are generated from this one package.
package nios_ext_ctrl_pkg;

    // Default sizing of the output-control port
    localparam int EXT_OUT_WIDTH_DEF = 4;
    localparam int EXT_OUT_CNT_W_DEF = 16;

    // Output-control port word offsets
    localparam logic [2:0] EXT_OUT_DATA        = 3'd0;
    localparam logic [2:0] EXT_OUT_PULSE_WIDTH = 3'd1;
    localparam logic [2:0] EXT_OUT_PULSE_TRIG  = 3'd2;
    localparam logic [2:0] EXT_OUT_DONE        = 3'd3;
    localparam logic [2:0] EXT_OUT_IRQ_MASK    = 3'd4;
    localparam logic [2:0] EXT_OUT_OUTSET      = 3'd5;
    localparam logic [2:0] EXT_OUT_OUTCLR      = 3'd6;

    // Edge-capturing input port word offsets
    localparam logic [2:0] EXT_IN_DATA         = 3'd0;
    localparam logic [2:0] EXT_IN_IRQ_MASK     = 3'd2;
    localparam logic [2:0] EXT_IN_EDGE_CAPTURE = 3'd3;

    typedef enum logic {
        PT_IDLE = 1'b0,
        PT_RUN  = 1'b1
    } pulse_state_e;

endpackage

// File: rtl/ext_ctrl_pulse_timer.sv
// One output bit's pulse timer: a down-counter that runs for load_val cycles.
//
//  state   | meaning
//  --------+-----------------------------------------------------------
//  PT_IDLE | no pulse; active=0
//  PT_RUN  | pulse in progress; active=1, cnt_q holds remaining cycles
//
// A trig while running reloads the counter, so the pulse is stretched and
// the interrupted pulse produces no done_pulse.
module ext_ctrl_pulse_timer
    import nios_ext_ctrl_pkg::*;
#(
    parameter int CNT_W = EXT_OUT_CNT_W_DEF
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             trig,
    input  logic [CNT_W-1:0] load_val,
    output logic             active,
    output logic             done_pulse
);

    pulse_state_e     state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    // State and counter registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= PT_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state logic; done_pulse fires in the last RUN cycle
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        done_pulse = 1'b0;
        case (state_q)
            PT_IDLE: begin
                if (trig) begin
                    state_d = PT_RUN;
                    cnt_d   = load_val;
                end
            end
            PT_RUN: begin
                if (trig) begin
                    cnt_d = load_val;
                end else if (cnt_q == CNT_W'(1)) begin
                    state_d    = PT_IDLE;
                    cnt_d      = '0;
                    done_pulse = 1'b1;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            default: begin
                state_d = PT_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    assign active = (state_q == PT_RUN);

endmodule

// File: rtl/nios_ext_ctrl_out.sv
// Avalon-MM output-control port: level register, per-bit timed pulses that
// invert the level, sticky done capture and a masked level interrupt.
// Read latency is one cycle; no wait-request.
module nios_ext_ctrl_out
    import nios_ext_ctrl_pkg::*;
#(
    parameter int WIDTH = EXT_OUT_WIDTH_DEF,
    parameter int CNT_W = EXT_OUT_CNT_W_DEF
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [2:0]       address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    output logic [31:0]      readdata,
    output logic [WIDTH-1:0] out_port,
    output logic             irq
);

    logic [WIDTH-1:0] data_q, data_d;
    logic [CNT_W-1:0] pw_q, pw_d;
    logic [WIDTH-1:0] done_q, done_d;
    logic [WIDTH-1:0] mask_q, mask_d;
    logic [31:0]      readdata_q, readdata_d;

    logic             wr;
    logic [WIDTH-1:0] wd;
    logic [WIDTH-1:0] trig;
    logic [WIDTH-1:0] active;
    logic [WIDTH-1:0] done_pulse;
    logic [CNT_W-1:0] load_val;
    logic             unused_wd;

    assign wr        = chipselect && !write_n;
    assign wd        = writedata[WIDTH-1:0];
    assign unused_wd = ^writedata;

    // A zero width still gives a one-cycle pulse
    assign load_val = (pw_q == '0) ? CNT_W'(1) : pw_q;
    assign trig     = (wr && address == EXT_OUT_PULSE_TRIG) ? wd : '0;

    // Per-bit pulse engines
    for (genvar i = 0; i < WIDTH; i++) begin : g_timer
        ext_ctrl_pulse_timer #(
            .CNT_W (CNT_W)
        ) u_timer (
            .clk        (clk),
            .reset      (reset),
            .trig       (trig[i]),
            .load_val   (load_val),
            .active     (active[i]),
            .done_pulse (done_pulse[i])
        );
    end

    // Register-file write decode and done capture (completion beats clear)
    always_comb begin
        data_d = data_q;
        pw_d   = pw_q;
        mask_d = mask_q;
        done_d = done_q;
        if (wr) begin
            case (address)
                EXT_OUT_DATA:        data_d = wd;
                EXT_OUT_PULSE_WIDTH: pw_d   = writedata[CNT_W-1:0];
                EXT_OUT_DONE:        done_d = '0;
                EXT_OUT_IRQ_MASK:    mask_d = wd;
                EXT_OUT_OUTSET:      data_d = data_q | wd;
                EXT_OUT_OUTCLR:      data_d = data_q & ~wd;
                default:             ;
            endcase
        end
        done_d = done_d | done_pulse;
    end

    // Read mux; write-only and reserved offsets read as zero
    always_comb begin
        readdata_d = '0;
        case (address)
            EXT_OUT_DATA:        readdata_d[WIDTH-1:0] = data_q;
            EXT_OUT_PULSE_WIDTH: readdata_d[CNT_W-1:0] = pw_q;
            EXT_OUT_PULSE_TRIG:  readdata_d[WIDTH-1:0] = active;
            EXT_OUT_DONE:        readdata_d[WIDTH-1:0] = done_q;
            EXT_OUT_IRQ_MASK:    readdata_d[WIDTH-1:0] = mask_q;
            default:             ;
        endcase
    end

    // Register update
    always_ff @(posedge clk) begin
        if (reset) begin
            data_q     <= '0;
            pw_q       <= '0;
            done_q     <= '0;
            mask_q     <= '0;
            readdata_q <= '0;
        end else begin
            data_q     <= data_d;
            pw_q       <= pw_d;
            done_q     <= done_d;
            mask_q     <= mask_d;
            readdata_q <= readdata_d;
        end
    end

    assign readdata = readdata_q;
    assign out_port = data_q ^ active;
    assign irq      = |(done_q & mask_q);

endmodule

// File: tb/tb_nios_ext_ctrl_out.sv
// Directed bench for nios_ext_ctrl_out: bus writes/reads on the negedge,
// outputs sampled on the negedge, hand-computed expectations.
module tb_nios_ext_ctrl_out;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [2:0]  address = 3'd7;
    logic        chipselect = 1'b0;
    logic        write_n = 1'b1;
    logic [31:0] writedata = '0;
    logic [31:0] readdata;
    logic [3:0]  out_port;
    logic        irq;

    int n_vec = 0;
    int n_err = 0;
    logic [31:0] rd;

    always #5 clk = ~clk;

    nios_ext_ctrl_out #(
        .WIDTH (4),
        .CNT_W (16)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .address    (address),
        .chipselect (chipselect),
        .write_n    (write_n),
        .writedata  (writedata),
        .readdata   (readdata),
        .out_port   (out_port),
        .irq        (irq)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Write is captured on the posedge following the call; returns one negedge later
    task automatic bus_write(input logic [2:0] a, input logic [31:0] d);
        address    = a;
        writedata  = d;
        chipselect = 1'b1;
        write_n    = 1'b0;
        @(negedge clk);
        chipselect = 1'b0;
        write_n    = 1'b1;
        address    = 3'd7;
        writedata  = '0;
    endtask

    task automatic bus_read(input logic [2:0] a, output logic [31:0] d);
        address = a;
        @(negedge clk);
        d       = readdata;
        address = 3'd7;
    endtask

    initial begin
        repeat (3) @(negedge clk);
        reset = 1'b0;

        // 1: reset state
        for (int a = 0; a < 8; a++) begin
            bus_read(3'(a), rd);
            check($sformatf("reset_rd%0d", a), rd, 32'h0);
        end
        check("reset_out", {28'h0, out_port}, 32'h0);
        check("reset_irq", {31'h0, irq}, 32'h0);

        // 2: level register, set and clear
        bus_write(3'd0, 32'h5);
        check("data_out", {28'h0, out_port}, 32'h5);
        bus_write(3'd5, 32'h2);
        check("outset_out", {28'h0, out_port}, 32'h7);
        bus_write(3'd6, 32'h4);
        check("outclr_out", {28'h0, out_port}, 32'h3);
        bus_read(3'd0, rd);
        check("data_rd", rd, 32'h3);
        bus_read(3'd5, rd);
        check("outset_rd", rd, 32'h0);
        bus_write(3'd7, 32'hF);
        bus_read(3'd7, rd);
        check("rsvd_rd", rd, 32'h0);
        check("rsvd_out", {28'h0, out_port}, 32'h3);

        // 3: width-3 positive pulse on bit 0
        bus_write(3'd0, 32'h0);
        bus_write(3'd1, 32'h3);
        bus_write(3'd4, 32'h1);
        bus_read(3'd1, rd);
        check("pw_rd", rd, 32'h3);
        bus_write(3'd2, 32'h1);
        for (int k = 1; k <= 3; k++) begin
            check($sformatf("p3_out_c%0d", k), {28'h0, out_port}, 32'h1);
            check($sformatf("p3_irq_c%0d", k), {31'h0, irq}, 32'h0);
            @(negedge clk);
        end
        check("p3_out_end", {28'h0, out_port}, 32'h0);
        check("p3_irq_end", {31'h0, irq}, 32'h1);
        bus_read(3'd3, rd);
        check("p3_done_rd", rd, 32'h1);
        bus_write(3'd3, 32'h0);
        check("p3_irq_clr", {31'h0, irq}, 32'h0);

        // 4: zero width gives one-cycle negative pulse
        bus_write(3'd1, 32'h0);
        bus_write(3'd0, 32'hF);
        bus_write(3'd2, 32'h8);
        check("p0_out_c1", {28'h0, out_port}, 32'h7);
        @(negedge clk);
        check("p0_out_c2", {28'h0, out_port}, 32'hF);
        bus_read(3'd3, rd);
        check("p0_done_rd", rd, 32'h8);
        check("p0_irq", {31'h0, irq}, 32'h0);

        // 5: retrigger at N+5 stretches width-10 pulse to N+15
        bus_write(3'd3, 32'h0);
        bus_write(3'd0, 32'h0);
        bus_write(3'd4, 32'h2);
        bus_write(3'd1, 32'd10);
        bus_write(3'd2, 32'h2);
        for (int k = 1; k <= 4; k++) begin
            check($sformatf("rt_out_c%0d", k), {28'h0, out_port}, 32'h2);
            @(negedge clk);
        end
        bus_write(3'd2, 32'h2);
        for (int k = 6; k <= 15; k++) begin
            check($sformatf("rt_out_c%0d", k), {28'h0, out_port}, 32'h2);
            check($sformatf("rt_irq_c%0d", k), {31'h0, irq}, 32'h0);
            @(negedge clk);
        end
        check("rt_out_end", {28'h0, out_port}, 32'h0);
        check("rt_irq_end", {31'h0, irq}, 32'h1);
        bus_write(3'd3, 32'h0);
        repeat (12) @(negedge clk);
        bus_read(3'd3, rd);
        check("rt_done_once", rd, 32'h0);

        // 6a: DONE clear on completion edge; completion wins, others cleared
        bus_write(3'd4, 32'h0);
        bus_write(3'd1, 32'h0);
        bus_write(3'd2, 32'h4);
        @(negedge clk);
        bus_read(3'd3, rd);
        check("race_pre_done", rd, 32'h4);
        bus_write(3'd1, 32'h2);
        bus_write(3'd2, 32'h1);
        @(negedge clk);
        bus_write(3'd3, 32'h0);
        bus_read(3'd3, rd);
        check("race_done", rd, 32'h1);

        // 6b: reset mid-pulse aborts without done
        bus_write(3'd3, 32'h0);
        bus_write(3'd0, 32'h5);
        bus_write(3'd1, 32'd10);
        bus_write(3'd2, 32'h1);
        check("abort_pre_out", {28'h0, out_port}, 32'h4);
        repeat (3) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("abort_out", {28'h0, out_port}, 32'h0);
        bus_read(3'd2, rd);
        check("abort_active", rd, 32'h0);
        repeat (12) @(negedge clk);
        bus_read(3'd3, rd);
        check("abort_done", rd, 32'h0);
        check("abort_out_late", {28'h0, out_port}, 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
